// File: rtl/random_pulse_array.sv
// random_pulse_array
//
// Bank of independent random pulse channels that emulate radioactive sources
// feeding a detector front end. Each channel runs a Fibonacci LFSR and fires a
// Bernoulli event whenever the LFSR value is below a shared rate threshold.
// Each event produces a PULSE_LEN-cycle pulse followed by DEAD_TIME forced-low
// cycles. Events arriving while a channel is busy are dropped
// (non-paralyzable). A saturating counter totals all accepted events.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   ena          advances the LFSRs and allows new events
//   rate         event threshold; a channel fires when lfsr < rate
//   count_clr    synchronous clear of event_count (wins over increments)
//   pulse        per-channel registered pulse
//   any_pulse    registered OR of all pulse bits (same timing as pulse)
//   event_count  saturating total of accepted events
//   lfsr0        current LFSR state of channel 0
module random_pulse_array #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      CHANNELS  = 4,
  parameter logic [WIDTH-1:0] SEED      = 16'h0001,
  parameter int unsigned      PULSE_LEN = 1,
  parameter int unsigned      DEAD_TIME = 0,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [WIDTH-1:0]    rate,
  input  logic                count_clr,
  output logic [CHANNELS-1:0] pulse,
  output logic                any_pulse,
  output logic [CNT_W-1:0]    event_count,
  output logic [WIDTH-1:0]    lfsr0
);

  // Parameter legality
  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
    $error("random_pulse_array: WIDTH must be 8, 16, 24 or 32");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("random_pulse_array: CHANNELS must be 1..16");
  end
  if (PULSE_LEN < 1) begin : g_bad_pulse_len
    $error("random_pulse_array: PULSE_LEN must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("random_pulse_array: CNT_W must be at least 1");
  end

  // Feedback tap masks for each legal width
  localparam logic [31:0] TAPS32 = (WIDTH == 8)  ? 32'h0000_00B8 :
                                   (WIDTH == 16) ? 32'h0000_D008 :
                                   (WIDTH == 24) ? 32'h00E1_0000 :
                                                   32'h8020_0003;
  localparam logic [WIDTH-1:0] TAPS = TAPS32[WIDTH-1:0];

  // An all-zero seed would lock the LFSR, so it is replaced by 1
  localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

  // Shared timer sized for the longer of the pulse and dead phases
  localparam int unsigned TMR_MAX = (PULSE_LEN > DEAD_TIME) ? PULSE_LEN : DEAD_TIME;
  localparam int unsigned TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  // Counter adder is wide enough to hold CNT_W ones plus up to 16 fires
  localparam int unsigned SW = CNT_W + 5;

  typedef enum logic [1:0] {StIdle, StPulse, StDead} state_e;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int unsigned s);
    logic [2*WIDTH-1:0] d;
    d = {v, v} << s;
    return d[2*WIDTH-1:WIDTH];
  endfunction

  logic [CHANNELS-1:0] fire;
  logic [CHANNELS-1:0] pulse_nxt;
  logic [CHANNELS-1:0] pulse_vec;

  for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
    localparam logic [WIDTH-1:0] CH_SEED = rotl(SEED_NZ, (3 * i) % WIDTH);

    logic [WIDTH-1:0] lfsr_q;
    state_e           state_q;
    logic [TW-1:0]    tmr_q;
    logic             pulse_q;

    assign fire[i]      = ena && (state_q == StIdle) && (lfsr_q < rate);
    // High for the fire cycle's successor and while the pulse timer is running
    assign pulse_nxt[i] = fire[i] || ((state_q == StPulse) && (tmr_q != '0));
    assign pulse_vec[i] = pulse_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lfsr_q  <= CH_SEED;
        state_q <= StIdle;
        tmr_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        // LFSR free-runs on ena regardless of channel state
        if (ena) begin
          lfsr_q <= {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
        end
        pulse_q <= pulse_nxt[i];
        unique case (state_q)
          StIdle: begin
            if (fire[i]) begin
              state_q <= StPulse;
              tmr_q   <= TW'(PULSE_LEN - 1);
            end
          end
          StPulse: begin
            if (tmr_q == '0) begin
              if (DEAD_TIME > 0) begin
                state_q <= StDead;
                tmr_q   <= TW'(DEAD_TIME - 1);
              end else begin
                state_q <= StIdle;
              end
            end else begin
              tmr_q <= tmr_q - TW'(1);
            end
          end
          StDead: begin
            if (tmr_q == '0) begin
              state_q <= StIdle;
            end else begin
              tmr_q <= tmr_q - TW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign pulse = pulse_vec;
  assign lfsr0 = gen_ch[0].lfsr_q;

  // Event counter: popcount of this cycle's fires, added with saturation
  logic [4:0]       fire_pop;
  logic [SW-1:0]    cnt_sum;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             any_pulse_q;

  always_comb begin
    fire_pop = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      fire_pop = fire_pop + 5'(fire[k]);
    end
    cnt_sum = SW'(cnt_q) + SW'(fire_pop);
    if (count_clr) begin
      cnt_d = '0;
    end else if (|cnt_sum[SW-1:CNT_W]) begin
      cnt_d = '1;
    end else begin
      cnt_d = cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      any_pulse_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      any_pulse_q <= |pulse_nxt;
    end
  end

  assign event_count = cnt_q;
  assign any_pulse   = any_pulse_q;

endmodule

// File: tb/tb_random_pulse_array.sv
// Directed self-checking bench for random_pulse_array. Several instances with
// different parameter sets share clock, ena, rate and count_clr; each scenario
// releases only its own instance from reset.
module tb_random_pulse_array;

  logic        clk = 1'b0;
  logic        ena;
  logic        count_clr;
  logic [15:0] rate;
  logic        rst_kat, rst_shp, rst_thr, rst_sat, rst_ena;

  logic [3:0]  pulse_kat;
  logic        any_kat;
  logic [15:0] cnt_kat;
  logic [15:0] lfsr_kat;

  logic [0:0]  pulse_shp;
  logic        any_shp;
  logic [15:0] cnt_shp;
  logic [15:0] lfsr_shp;

  logic [0:0]  pulse_thr;
  logic        any_thr;
  logic [15:0] cnt_thr;
  logic [15:0] lfsr_thr;

  logic [3:0]  pulse_sat;
  logic        any_sat;
  logic [3:0]  cnt_sat;
  logic [15:0] lfsr_sat;

  logic [3:0]  pulse_ena;
  logic        any_ena;
  logic [15:0] cnt_ena;
  logic [15:0] lfsr_ena;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  random_pulse_array #(
    .WIDTH(16), .CHANNELS(4), .SEED(16'h0001), .PULSE_LEN(1), .DEAD_TIME(0), .CNT_W(16)
  ) u_kat (
    .clk(clk), .rst(rst_kat), .ena(ena), .rate(rate), .count_clr(count_clr),
    .pulse(pulse_kat), .any_pulse(any_kat), .event_count(cnt_kat), .lfsr0(lfsr_kat)
  );

  random_pulse_array #(
    .WIDTH(16), .CHANNELS(1), .SEED(16'h0001), .PULSE_LEN(2), .DEAD_TIME(3), .CNT_W(16)
  ) u_shp (
    .clk(clk), .rst(rst_shp), .ena(ena), .rate(rate), .count_clr(count_clr),
    .pulse(pulse_shp), .any_pulse(any_shp), .event_count(cnt_shp), .lfsr0(lfsr_shp)
  );

  random_pulse_array #(
    .WIDTH(16), .CHANNELS(1), .SEED(16'h0001), .PULSE_LEN(4), .DEAD_TIME(0), .CNT_W(16)
  ) u_thr (
    .clk(clk), .rst(rst_thr), .ena(ena), .rate(rate), .count_clr(count_clr),
    .pulse(pulse_thr), .any_pulse(any_thr), .event_count(cnt_thr), .lfsr0(lfsr_thr)
  );

  random_pulse_array #(
    .WIDTH(16), .CHANNELS(4), .SEED(16'h0001), .PULSE_LEN(1), .DEAD_TIME(0), .CNT_W(4)
  ) u_sat (
    .clk(clk), .rst(rst_sat), .ena(ena), .rate(rate), .count_clr(count_clr),
    .pulse(pulse_sat), .any_pulse(any_sat), .event_count(cnt_sat), .lfsr0(lfsr_sat)
  );

  random_pulse_array #(
    .WIDTH(16), .CHANNELS(4), .SEED(16'h0001), .PULSE_LEN(3), .DEAD_TIME(2), .CNT_W(16)
  ) u_ena (
    .clk(clk), .rst(rst_ena), .ena(ena), .rate(rate), .count_clr(count_clr),
    .pulse(pulse_ena), .any_pulse(any_ena), .event_count(cnt_ena), .lfsr0(lfsr_ena)
  );

  // Advance one cycle and settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] kat [6];
    int bad_cycle;
    kat = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0011, 16'h0022};
    ena = 1'b0;
    rate = 16'h0000;
    @(negedge clk);
    rst_kat = 1'b0;
    ena = 1'b1;
    n_tests++;
    if (pulse_kat !== 4'h0 || any_kat !== 1'b0 || cnt_kat !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: pulse=%h any=%b count=%0d, want 0/0/0",
               pulse_kat, any_kat, cnt_kat);
    end
    for (int c = 0; c < 6; c++) begin
      n_tests++;
      if (lfsr_kat !== kat[c]) begin
        n_fail++;
        $display("FAIL kat_lfsr0 cycle %0d: got %h want %h", c, lfsr_kat, kat[c]);
      end
      tick();
    end
    bad_cycle = -1;
    for (int c = 0; c < 1000; c++) begin
      if ((pulse_kat !== 4'h0 || cnt_kat !== 16'd0) && bad_cycle < 0) bad_cycle = c;
      tick();
    end
    n_tests++;
    if (bad_cycle >= 0) begin
      n_fail++;
      $display("FAIL rate0_quiet: activity at cycle %0d (pulse=%h count=%0d), want none",
               bad_cycle, pulse_kat, cnt_kat);
    end
    rst_kat = 1'b1;
  endtask

  task automatic test_pulse_shape();
    logic [17:0] exp_p;
    exp_p = 18'b000110000110000110;
    ena = 1'b0;
    rate = 16'hFFFF;
    @(negedge clk);
    rst_shp = 1'b0;
    ena = 1'b1;
    for (int c = 0; c < 18; c++) begin
      n_tests++;
      if (pulse_shp[0] !== exp_p[c] || any_shp !== exp_p[c]) begin
        n_fail++;
        $display("FAIL shape_pulse cycle %0d: pulse=%b any=%b want %b",
                 c, pulse_shp[0], any_shp, exp_p[c]);
      end
      if (c == 1 || c == 7 || c == 13) begin
        n_tests++;
        if (cnt_shp !== 16'((c + 5) / 6)) begin
          n_fail++;
          $display("FAIL shape_count cycle %0d: got %0d want %0d", c, cnt_shp, (c + 5) / 6);
        end
      end
      tick();
    end
    rst_shp = 1'b1;
  endtask

  task automatic test_threshold();
    logic [10:0] exp_p;
    exp_p = 11'b000_0001_1110;
    ena = 1'b0;
    rate = 16'd3;
    @(negedge clk);
    rst_thr = 1'b0;
    ena = 1'b1;
    for (int c = 0; c < 11; c++) begin
      n_tests++;
      if (pulse_thr[0] !== exp_p[c]) begin
        n_fail++;
        $display("FAIL thr_pulse cycle %0d: got %b want %b", c, pulse_thr[0], exp_p[c]);
      end
      if (c == 1) begin
        n_tests++;
        if (lfsr_thr !== 16'h0002) begin
          n_fail++;
          $display("FAIL thr_lfsr cycle 1: got %h want 0002", lfsr_thr);
        end
      end
      if (c == 2 || c == 10) begin
        n_tests++;
        if (cnt_thr !== 16'd1) begin
          n_fail++;
          $display("FAIL thr_count cycle %0d: got %0d want 1", c, cnt_thr);
        end
      end
      tick();
    end
    rst_thr = 1'b1;
  endtask

  task automatic test_saturation();
    logic [3:0] exp_c [10];
    exp_c = '{4'd0, 4'd4, 4'd4, 4'd8, 4'd8, 4'd12, 4'd12, 4'd15, 4'd15, 4'd15};
    ena = 1'b0;
    rate = 16'hFFFF;
    count_clr = 1'b0;
    @(negedge clk);
    rst_sat = 1'b0;
    ena = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c % 2 == 1 || c == 0) begin
        n_tests++;
        if (cnt_sat !== exp_c[c]) begin
          n_fail++;
          $display("FAIL sat_count cycle %0d: got %0d want %0d", c, cnt_sat, exp_c[c]);
        end
      end
      if (c == 1 || c == 2) begin
        n_tests++;
        if (pulse_sat !== ((c == 1) ? 4'hF : 4'h0)) begin
          n_fail++;
          $display("FAIL sat_pulse cycle %0d: got %h want %h",
                   c, pulse_sat, (c == 1) ? 4'hF : 4'h0);
        end
      end
      tick();
    end
    // Cycle 10 is a fire cycle; clear must win over its increments
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    n_tests++;
    if (cnt_sat !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_clear: got %0d want 0", cnt_sat);
    end
    tick();
    tick();
    n_tests++;
    if (cnt_sat !== 4'd4) begin
      n_fail++;
      $display("FAIL sat_after_clear: got %0d want 4", cnt_sat);
    end
    rst_sat = 1'b1;
  endtask

  task automatic test_ena_gating();
    logic [10:0] exp_p;
    exp_p = 11'b100_0000_1110;
    ena = 1'b0;
    rate = 16'hFFFF;
    @(negedge clk);
    rst_ena = 1'b0;
    ena = 1'b1;
    for (int c = 0; c < 11; c++) begin
      n_tests++;
      if (pulse_ena !== (exp_p[c] ? 4'hF : 4'h0)) begin
        n_fail++;
        $display("FAIL ena_pulse cycle %0d: got %h want %h",
                 c, pulse_ena, exp_p[c] ? 4'hF : 4'h0);
      end
      if (c == 3 || c == 9) begin
        n_tests++;
        if (lfsr_ena !== 16'h0002 || cnt_ena !== 16'd4) begin
          n_fail++;
          $display("FAIL ena_hold cycle %0d: lfsr0=%h count=%0d want 0002/4", c, lfsr_ena, cnt_ena);
        end
      end
      if (c == 10) begin
        n_tests++;
        if (lfsr_ena !== 16'h0004 || cnt_ena !== 16'd8) begin
          n_fail++;
          $display("FAIL ena_resume: lfsr0=%h count=%0d want 0004/8", lfsr_ena, cnt_ena);
        end
      end
      if (c == 1) ena = 1'b0;
      if (c == 9) ena = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    ena = 1'b0;
    rate = 16'hFFFF;
    rst_ena = 1'b1;
    @(negedge clk);
    rst_ena = 1'b0;
    ena = 1'b1;
    tick();
    tick();
    n_tests++;
    if (pulse_ena !== 4'hF) begin
      n_fail++;
      $display("FAIL mid_pre: pulse=%h want f", pulse_ena);
    end
    #2;
    rst_ena = 1'b1;
    #1;
    n_tests++;
    if (pulse_ena !== 4'h0 || any_ena !== 1'b0 || cnt_ena !== 16'd0 || lfsr_ena !== 16'h0001)
    begin
      n_fail++;
      $display("FAIL mid_reset: pulse=%h any=%b count=%0d lfsr0=%h want 0/0/0/0001",
               pulse_ena, any_ena, cnt_ena, lfsr_ena);
    end
    @(negedge clk);
    rst_ena = 1'b0;
    tick();
    n_tests++;
    if (pulse_ena !== 4'hF || cnt_ena !== 16'd4 || lfsr_ena !== 16'h0002) begin
      n_fail++;
      $display("FAIL mid_restart: pulse=%h count=%0d lfsr0=%h want f/4/0002",
               pulse_ena, cnt_ena, lfsr_ena);
    end
    rst_ena = 1'b1;
  endtask

  initial begin
    ena = 1'b0;
    count_clr = 1'b0;
    rate = 16'h0000;
    rst_kat = 1'b1;
    rst_shp = 1'b1;
    rst_thr = 1'b1;
    rst_sat = 1'b1;
    rst_ena = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_pulse_shape();
    test_threshold();
    test_saturation();
    test_ena_gating();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/random_pulse_array.md
# random_pulse_array

Multi-channel, parametrised random pulse source that emulates a set of independent radioactive sources feeding a detector front end. Each channel runs its own LFSR and fires Bernoulli events against a shared programmable rate threshold. Each event produces a fixed-width output pulse followed by a non-paralyzable dead time. A shared saturating counter totals accepted events across all channels for downstream rate checks.

## Interface

Parameters:
- WIDTH, 16: LFSR and rate width; legal values 8, 16, 24, 32; any other value is an elaboration error.
- CHANNELS, 4: number of independent channels, 1..16.
- SEED, 16'h0001: base seed, WIDTH bits; a value of 0 is replaced by 1.
- PULSE_LEN, 1: output high time in cycles, ≥1; 0 is an elaboration error.
- DEAD_TIME, 0: cycles of forced low after each pulse, ≥0.
- CNT_W, 16: width of the event counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  advances the LFSRs and allows new events.
- rate  in  WIDTH  event threshold; a channel fires when its LFSR value is strictly less than rate.
- count_clr  in  1  synchronous clear of event_count.
- pulse  out  CHANNELS  per-channel pulse, registered.
- any_pulse  out  1  registered OR of all next-cycle pulse bits; equals |pulse.
- event_count  out  CNT_W  saturating total of accepted events.
- lfsr0  out  WIDTH  current LFSR state of channel 0, for verification.

## Operation

- LFSR per channel, Fibonacci, shift left, feedback bit shifted into bit 0.
- Feedback is the XOR of these state bits:
  - WIDTH 8: bits 7,5,4,3.
  - WIDTH 16: bits 15,14,12,3.
  - WIDTH 24: bits 23,22,21,16.
  - WIDTH 32: bits 31,21,1,0.
- Channel i seed = SEED rotated left by (3*i) mod WIDTH. The seed is never zero.
- LFSRs advance every cycle that ena=1, regardless of channel state. They hold when ena=0.
- Per-channel FSM: IDLE, PULSE, DEAD.
  - IDLE: fire = ena & (lfsr_i < rate). On fire, go to PULSE and load a down-counter with PULSE_LEN-1.
  - PULSE: pulse_i=1. At count 0, go to DEAD (loaded DEAD_TIME-1) if DEAD_TIME>0, else go to IDLE.
  - DEAD: pulse_i=0. At count 0, go to IDLE.
  - Events are evaluated only in IDLE. Candidate events during PULSE or DEAD are discarded and not counted (non-paralyzable).
- ena=0 does not abort a PULSE or DEAD sequence already in progress; it completes normally.
- Rate boundaries:
  - rate=0: never fires.
  - rate=2^WIDTH-1: fires on every IDLE cycle except when the LFSR equals all-ones.
- Fire-to-fire period at maximal rate = PULSE_LEN + DEAD_TIME + 1 cycles.
- event_count:
  - Each cycle, adds the popcount of the fire vector, saturating at 2^CNT_W-1. The add is computed at CNT_W+5 bits, then clamped.
  - count_clr=1 sets it to 0 and discards that cycle's increments (clear wins).

## Timing

- Reset (asynchronous, immediate):
  - pulse=0, any_pulse=0, event_count=0.
  - All FSMs go to IDLE and all LFSRs reload their seeds, so lfsr0 = SEED (or 1 if SEED=0).
  - Reset mid-pulse drops pulse at once. The first post-reset event is evaluated on the first rising edge after rst falls.
- Latency: fire is evaluated combinationally in cycle n from the current LFSR. pulse_i is high in cycles n+1 .. n+PULSE_LEN.
- event_count reflects a cycle-n fire from cycle n+1, aligned with the pulse rising.
- any_pulse has the same timing as pulse, with no extra latency.
- Changes to rate take effect on the very next evaluation; there is no internal pipeline.

## Test plan

- Reset/KAT:
  - Stimulus: WIDTH=16, SEED=1, rst pulse, then ena=1, rate=0.
  - Required: lfsr0 = 0x0001, 0x0002, 0x0004, 0x0008, 0x0011, 0x0022 on successive cycles.
  - Required: pulse=0 and event_count=0 throughout 1000 cycles.
- Pulse/dead shape:
  - Stimulus: CHANNELS=1, PULSE_LEN=2, DEAD_TIME=3, rate=0xFFFF, ena=1 from cycle 0.
  - Required: pulse high in cycles 1–2, low 3–5, high 7–8, and so on with period 6.
  - Required: event_count = 1, 2, 3 at cycles 1, 7, 13.
- Threshold and discard:
  - Stimulus: CHANNELS=1, PULSE_LEN=4, rate=3, SEED=1.
  - Required: fire at cycle 0 (lfsr 1<3), pulse high in cycles 1–4.
  - Required: no fire during those cycles, even though lfsr=2 at cycle 1; event_count=1 afterwards.
- Saturation and clear:
  - Stimulus: CNT_W=4, CHANNELS=4, PULSE_LEN=1, rate=max.
  - Required: event_count reaches 15 after the 4th fire cycle and holds at 15.
  - Required: count_clr asserted in a fire cycle gives 0 on the next cycle.
- ena gating:
  - Stimulus: drop ena mid-pulse with PULSE_LEN=3.
  - Required: the pulse completes its 3 cycles, lfsr0 holds its value, and there are no new fires until ena=1.
- Reset mid-operation:
  - Stimulus: assert rst while pulse=1 and the DEAD state is pending on other channels.
  - Required: pulse drops immediately (before the next clk edge), event_count=0, and lfsr0 = SEED.
